// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_core
// Brief    : Oversampled UART receiver with 2-of-3 majority voting, optional
//            parity and one/two stop bits; one P_DATA word per good frame.
// Revision : 1.0
// ============================================================================
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  FRM_BUSY
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync_q, sync_d, rx_s_q, rx_s_d;
    logic [PRESCALE_W-1:0]   edge_cnt_q, edge_cnt_d, prescale_q, prescale_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]              samp_q, samp_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d, p_data_q, p_data_d;
    logic                    stop_idx_q, stop_idx_d;
    logic                    par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
    logic                    par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                    par_err_out_q, par_err_out_d, stp_err_out_q, stp_err_out_d;
    logic                    data_valid_q, data_valid_d;

    logic [PRESCALE_W-1:0]   w_half;
    logic                    w_sample_lo, w_sample_mid, w_decide, w_last, w_maj;

    assign w_half       = prescale_q >> 1;
    assign w_sample_lo  = (edge_cnt_q == w_half - PRESCALE_W'(1));
    assign w_sample_mid = (edge_cnt_q == w_half);
    assign w_decide     = (edge_cnt_q == w_half + PRESCALE_W'(1));
    assign w_last       = (edge_cnt_q == prescale_q - PRESCALE_W'(1));
    // Third vote is the live rx_s at the decision point.
    assign w_maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

    always_comb begin
        state_d       = state_q;
        sync_d        = RX_IN;
        rx_s_d        = sync_q;
        edge_cnt_d    = edge_cnt_q + PRESCALE_W'(1);
        prescale_d    = prescale_q;
        bit_cnt_d     = bit_cnt_q;
        samp_d        = samp_q;
        shreg_d       = shreg_q;
        p_data_d      = p_data_q;
        stop_idx_d    = stop_idx_q;
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        stop2_d       = stop2_q;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        par_err_out_d = par_err_out_q;
        stp_err_out_d = stp_err_out_q;
        data_valid_d  = 1'b0;

        if (w_sample_lo)  samp_d[0] = rx_s_q;
        if (w_sample_mid) samp_d[1] = rx_s_q;

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d    = S_START;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    stop2_d    = STOP2;
                    prescale_d = PRESCALE;
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                end
            end
            S_START: begin
                if (w_decide && w_maj) begin
                    state_d = S_IDLE;
                end else if (w_last) begin
                    state_d    = S_DATA;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_DATA: begin
                if (w_decide) shreg_d = {w_maj, shreg_q[DATA_WIDTH-1:1]};
                if (w_last) begin
                    edge_cnt_d = '0;
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        state_d    = par_en_q ? S_PARITY : S_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_decide) par_err_d = w_maj ^ (^shreg_q) ^ par_typ_q;
                if (w_last) begin
                    state_d    = S_STOP;
                    edge_cnt_d = '0;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                // Leave at the last decision so a back-to-back start edge is caught.
                if (w_decide) begin
                    if (!w_maj) stp_err_d = 1'b1;
                    if (!stop2_q || stop_idx_q) state_d = S_DONE;
                end
                if (w_last) begin
                    edge_cnt_d = '0;
                    stop_idx_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d       = S_IDLE;
                par_err_out_d = par_err_q;
                stp_err_out_d = stp_err_q;
                if (!par_err_q && !stp_err_q) begin
                    p_data_d     = shreg_q;
                    data_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= S_IDLE;
            sync_q        <= 1'b1;
            rx_s_q        <= 1'b1;
            edge_cnt_q    <= '0;
            prescale_q    <= '0;
            bit_cnt_q     <= '0;
            samp_q        <= '0;
            shreg_q       <= '0;
            p_data_q      <= '0;
            stop_idx_q    <= 1'b0;
            par_en_q      <= 1'b0;
            par_typ_q     <= 1'b0;
            stop2_q       <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
            par_err_out_q <= 1'b0;
            stp_err_out_q <= 1'b0;
            data_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            rx_s_q        <= rx_s_d;
            edge_cnt_q    <= edge_cnt_d;
            prescale_q    <= prescale_d;
            bit_cnt_q     <= bit_cnt_d;
            samp_q        <= samp_d;
            shreg_q       <= shreg_d;
            p_data_q      <= p_data_d;
            stop_idx_q    <= stop_idx_d;
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            stop2_q       <= stop2_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
            par_err_out_q <= par_err_out_d;
            stp_err_out_q <= stp_err_out_d;
            data_valid_q  <= data_valid_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_out_q;
    assign STP_ERR    = stp_err_out_q;
    assign FRM_BUSY   = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receive engine. It merges the receive control FSM with the edge/bit counters, the oversampled majority-vote sampler, the deserializer and the parity/stop checkers into one block. It sits between the RX_IN pin (asynchronous) and the UART register/FIFO layer, and delivers one P_DATA word per good frame. Data width, oversampling ratio, parity mode and stop-bit count are all configurable.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
PRESCALE_W, 6, width of the PRESCALE port.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
RX_IN  in  1  serial line, asynchronous, idles high
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even parity, 1 = odd parity
STOP2  in  1  1 = two stop bits
PRESCALE  in  PRESCALE_W  clocks per bit; even, >=8
P_DATA  out  DATA_WIDTH  last good received word, LSB first on the line
DATA_VALID  out  1  one-cycle pulse, P_DATA updated
PAR_ERR  out  1  parity error of the last completed frame
STP_ERR  out  1  stop error of the last completed frame
FRM_BUSY  out  1  high while state != IDLE

Behaviour:
- Reset value is 0 for P_DATA, DATA_VALID, PAR_ERR, STP_ERR and FRM_BUSY. Reset forces state to IDLE and clears all counters.
- Reset asserted mid-frame aborts the frame with no output pulse.
- RX_IN passes through a 2-flop synchronizer, giving rx_s. All timing below is relative to rx_s.
- Config latch: PAR_EN, PAR_TYP, STOP2 and PRESCALE are captured on the IDLE->START transition. Input changes mid-frame do not affect the current frame.
- edge_cnt runs 0..PRESCALE-1 and wraps to 0 at each bit boundary. bit_cnt counts data bits 0..DATA_WIDTH-1.
- Majority sampling: rx_s is sampled at edge_cnt = H-1, H and H+1, where H = PRESCALE/2.
  - The bit value is the 2-of-3 majority.
  - The decision point is edge_cnt = H+1, and the decision is usable on the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: rx_s = 0 -> START, edge_cnt = 0.
  - START: if the start bit decision is 1 (glitch), go to IDLE at the decision point with no flags changed. Otherwise, at edge_cnt = PRESCALE-1 go to DATA with bit_cnt = 0.
  - DATA: at the decision point, shift the bit into the shift register LSB-first. At edge_cnt = PRESCALE-1, if bit_cnt = DATA_WIDTH-1 go to PARITY (latched PAR_EN = 1) or to STOP; otherwise bit_cnt++.
  - PARITY: the decision is compared against the computed parity to give par_err_int. For even parity, expected = XOR of the data bits; for odd parity, expected = its inverse. At edge_cnt = PRESCALE-1 go to STOP.
  - STOP: a decision of 0 sets stp_err_int (sticky within the frame).
    - With STOP2 = 1, the first stop bit runs the full period, then the second stop bit is sampled.
    - The FSM leaves STOP at the decision point of the last stop bit. It does not wait for the bit end, so a back-to-back start edge is not missed.
  - DONE: lasts one cycle, then IDLE.
    - PAR_ERR <= par_err_int and STP_ERR <= stp_err_int.
    - If both are 0: P_DATA <= shift register and DATA_VALID = 1 for this cycle.
    - Otherwise P_DATA holds and DATA_VALID stays 0.
    - Error flags hold until the next DONE.
- DATA_VALID is registered. Its latency from the last-stop-bit decision cycle is 2 CLK.
- Internal error flags clear on entry to START.
- A low rx_s in the cycle right after DONE is taken as a new start.
- If PRESCALE < 8 or is odd, behaviour is undefined. The bench keeps it legal.

Test Plan:
1. DATA_WIDTH=8, PRESCALE=8, no parity, 1 stop, frame 0xA5 -> exactly one DATA_VALID pulse, P_DATA=0xA5, PAR_ERR=0, STP_ERR=0, FRM_BUSY back to 0.
2. Even parity, 0x3C sent with parity bit 0 -> valid, P_DATA=0x3C. Then 0x3C with parity bit 1 -> no pulse, PAR_ERR=1, P_DATA stays 0x3C. Then odd parity, 0x01 with parity bit 0 -> valid, PAR_ERR=0.
3. Stop bit driven 0 with 0x55 -> STP_ERR=1, no pulse. STOP2=1 with the second stop bit 0 -> STP_ERR=1. STOP2=1 with both stop bits 1 -> valid.
4. RX_IN low for 3 clocks then high (PRESCALE=8) -> START aborts to IDLE with no pulse and flags unchanged. A following clean frame 0x81 -> P_DATA=0x81.
5. Frame 0x00 with a 1-clock high spike at edge_cnt=H inside each data bit -> P_DATA=0x00 (majority rejects the spike). Two back-to-back frames 0x12 and 0x34 with no idle gap -> two pulses, values in order.
6. RST pulsed mid-DATA of a frame -> all outputs 0, state IDLE. The next complete frame 0xF0 is received correctly. PRESCALE changed mid-frame -> the current frame still decodes at the latched rate.
